// File: rtl/nano_rv32i_pkg.sv
// Shared definitions for the nano_rv32i data-bus bridge: FSM encoding and
// the fill pattern returned to the core when a load times out.
package nano_rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dbus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage : nano_rv32i_pkg

// File: rtl/nano_timeout_cnt.sv
// Counts cycles spent waiting for a memory acknowledge. expired_o rises in
// the TIMEOUT-th enabled cycle after a clear, so the request is held exactly TIMEOUT cycles.
module nano_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Saturates at TIMEOUT rather than wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr_i) begin
            cnt_next = '0;
        end else if (en_i && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign expired_o = en_i && (cnt_reg >= CNT_LAST);

endmodule : nano_timeout_cnt

// File: rtl/nano_dbus_bridge.sv
// Turns the core's single-cycle load/store strobes into a req/ack transaction
// toward slow data memory, stalling the core and flagging misaligned/timed-out accesses.
module nano_dbus_bridge
    import nano_rv32i_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_data_i,
    input  logic              d_rd_i,
    input  logic              d_wr_i,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_stall_o,
    output logic              bus_err_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_ack_i
);

    dbus_state_t       state_reg;
    dbus_state_t       state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic              access_req;
    logic              misaligned;
    logic              accept;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_expired;
    logic              req_comb;
    logic              stall_comb;

    assign access_req = d_rd_i | d_wr_i;
    assign misaligned = (d_addr_i[1:0] != 2'b00);
    assign accept     = (state_reg == ST_IDLE) && access_req;

    nano_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        req_comb   = 1'b0;
        stall_comb = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (access_req) begin
                    stall_comb = 1'b1;
                    if (misaligned) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_REQ;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_comb   = 1'b1;
                stall_comb = 1'b1;
                cnt_en     = 1'b1;
                if (m_ack_i || cnt_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Strobes still held by the core here belong to the finished access.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= {d_addr_i[ADDR_W-1:2], 2'b00};
                wdata_reg <= d_data_i;
                we_reg    <= d_wr_i;
                err_reg   <= misaligned;
            end
            // An acknowledge in the final counted cycle still wins over the timeout.
            if (state_reg == ST_REQ) begin
                if (m_ack_i) begin
                    if (!we_reg) begin
                        rdata_reg <= m_rdata_i;
                    end
                end else if (cnt_expired) begin
                    err_reg <= 1'b1;
                    if (!we_reg) begin
                        rdata_reg <= DATA_W'(BUS_ERR_DATA);
                    end
                end
            end
        end
    end

    assign m_req_o   = req_comb;
    assign m_we_o    = we_reg;
    assign m_addr_o  = addr_reg;
    assign m_wdata_o = wdata_reg;
    assign d_data_o  = rdata_reg;
    assign d_stall_o = rst_n_i & stall_comb;
    assign bus_err_o = (state_reg == ST_DONE) & err_reg;

endmodule : nano_dbus_bridge

// File: tb/tb_nano_dbus_bridge.sv
// Directed bench for nano_dbus_bridge: a small memory responder answers requests,
// and expected completions are queued per access and checked when the core is released.
module tb_nano_dbus_bridge;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic        d_rd_i;
    logic        d_wr_i;
    logic [31:0] d_data_o;
    logic        d_stall_o;
    logic        bus_err_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        m_ack_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] data;
        int          req_cycles;
        int          stall_cycles;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_rd_data;

    always #5 clk = ~clk;

    nano_dbus_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .d_addr_i  (d_addr_i),
        .d_data_i  (d_data_i),
        .d_rd_i    (d_rd_i),
        .d_wr_i    (d_wr_i),
        .d_data_o  (d_data_o),
        .d_stall_o (d_stall_o),
        .bus_err_o (bus_err_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_rdata_i (m_rdata_i),
        .m_ack_i   (m_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One core access. ack_delay < 0 means the memory never answers.
    // With settle=1 an idle cycle follows so a stray error pulse or restart is visible.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_delay, input logic [31:0] rdata, input bit settle);
        exp_t e;
        exp_t got;
        logic is_read;
        int   reqc;
        int   stallc;
        int   errc;
        int   cyc;
        bit   done;
        bit   req_bad;
        logic err_at_done;
        logic [31:0] data_at_done;

        is_read = rd & ~wr;
        if (addr[1:0] != 2'b00) begin
            e.req_cycles = 0; e.stall_cycles = 1; e.err = 1'b1; e.data = last_rd_data;
        end else if (ack_delay < 0 || ack_delay >= TIMEOUT) begin
            e.req_cycles = TIMEOUT; e.stall_cycles = TIMEOUT + 1; e.err = 1'b1;
            e.data = is_read ? 32'hDEAD_BEEF : last_rd_data;
        end else begin
            e.req_cycles = ack_delay + 1; e.stall_cycles = ack_delay + 2; e.err = 1'b0;
            e.data = is_read ? rdata : last_rd_data;
        end
        last_rd_data = e.data;
        sb_q.push_back(e);

        d_rd_i = rd; d_wr_i = wr; d_addr_i = addr; d_data_i = wdata;
        reqc = 0; stallc = 0; errc = 0; cyc = 0; done = 0; req_bad = 0;
        err_at_done = 1'b0; data_at_done = '0;
        while (!done && cyc < 64) begin
            if (m_req_o) begin
                reqc++;
                if (m_addr_o !== {addr[31:2], 2'b00} || m_we_o !== wr ||
                    (wr && m_wdata_o !== wdata)) req_bad = 1;
                m_ack_i   = (ack_delay >= 0) && (reqc == ack_delay + 1);
                m_rdata_i = rdata;
            end else begin
                m_ack_i = 1'b0;
            end
            @(negedge clk);
            if (d_stall_o) stallc++;
            if (bus_err_o) errc++;
            if (!d_stall_o && cyc > 0) begin
                done = 1;
                err_at_done  = bus_err_o;
                data_at_done = d_data_o;
            end
            step();
            cyc++;
        end
        d_rd_i = 1'b0; d_wr_i = 1'b0; m_ack_i = 1'b0;
        check({tag, ":completed"}, 32'(done), 32'd1);
        if (settle) begin
            @(negedge clk);
            if (bus_err_o) errc++;
            if (m_req_o) reqc++;
            step();
        end
        got = sb_q.pop_front();
        check({tag, ":d_data"}, data_at_done, got.data);
        check({tag, ":err_in_done"}, 32'(err_at_done), 32'(got.err));
        check({tag, ":err_pulses"}, 32'(errc), 32'(got.err));
        check({tag, ":req_cycles"}, 32'(reqc), 32'(got.req_cycles));
        check({tag, ":stall_cycles"}, 32'(stallc), 32'(got.stall_cycles));
        check({tag, ":req_fields_stable"}, 32'(req_bad), 32'd0);
        $display("[TB] %s rd=%0b wr=%0b addr=%h req=%0d stall=%0d err=%0d data=%h",
                 tag, rd, wr, addr, reqc, stallc, errc, data_at_done);
    endtask

    initial begin
        rst_n_i = 1'b0; d_addr_i = 32'h10; d_data_i = '0; d_rd_i = 1'b1; d_wr_i = 1'b0;
        m_rdata_i = '0; m_ack_i = 1'b0;
        last_rd_data = '0;
        repeat (3) step();
        @(negedge clk);
        check("reset:stall_forced", 32'(d_stall_o), 32'd0);
        check("reset:m_req", 32'(m_req_o), 32'd0);
        check("reset:d_data", d_data_o, 32'd0);
        check("reset:bus_err", 32'(bus_err_o), 32'd0);
        check("reset:m_addr", m_addr_o, 32'd0);
        check("reset:m_we", 32'(m_we_o), 32'd0);
        step();
        rst_n_i = 1'b1; d_rd_i = 1'b0;
        step();

        do_access("rd_fast",     1'b1, 1'b0, 32'h10, 32'h0,        0, 32'h1234_5678, 1'b1);
        do_access("wr_slow",     1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 3, 32'h5555_5555, 1'b1);
        do_access("rd_misalign", 1'b1, 1'b0, 32'h13, 32'h0,        0, 32'h0,         1'b1);
        do_access("rd_timeout",  1'b1, 1'b0, 32'h30, 32'h0,       -1, 32'h0,         1'b1);
        do_access("rd_b2b_a",    1'b1, 1'b0, 32'h44, 32'h0,        1, 32'hA5A5_0F0F, 1'b0);
        do_access("rd_b2b_b",    1'b1, 1'b0, 32'h48, 32'h0,       14, 32'h0BAD_CAFE, 1'b1);
        do_access("wr_timeout",  1'b0, 1'b1, 32'h4C, 32'h1357_9BDF, -1, 32'h0,       1'b1);

        // Reset in the middle of a read.
        d_rd_i = 1'b1; d_addr_i = 32'h40;
        step();
        step();
        check("midrst:req_before", 32'(m_req_o), 32'd1);
        rst_n_i = 1'b0;
        @(negedge clk);
        check("midrst:stall_forced", 32'(d_stall_o), 32'd0);
        step();
        rst_n_i = 1'b1; d_rd_i = 1'b0;
        @(negedge clk);
        check("midrst:req_after", 32'(m_req_o), 32'd0);
        check("midrst:stall_after", 32'(d_stall_o), 32'd0);
        step();
        m_ack_i = 1'b1; m_rdata_i = 32'h7777_7777;
        step();
        m_ack_i = 1'b0;
        @(negedge clk);
        last_rd_data = 32'd0;
        check("midrst:late_ack_data", d_data_o, last_rd_data);
        check("midrst:late_ack_req", 32'(m_req_o), 32'd0);
        check("midrst:late_ack_err", 32'(bus_err_o), 32'd0);
        $display("[TB] midrst addr=00000040 req=%0b stall=%0b data=%h", m_req_o, d_stall_o, d_data_o);
        step();

        do_access("rd_after_rst", 1'b1, 1'b0, 32'h50, 32'h0, 2, 32'h0F1E_2D3C, 1'b1);

        // Spurious acknowledge while idle, then simultaneous rd+wr.
        m_ack_i = 1'b1; m_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        check("spurious:stall", 32'(d_stall_o), 32'd0);
        step();
        m_ack_i = 1'b0;
        @(negedge clk);
        check("spurious:req", 32'(m_req_o), 32'd0);
        check("spurious:d_data", d_data_o, last_rd_data);
        $display("[TB] spurious_ack req=%0b data=%h", m_req_o, d_data_o);
        step();
        do_access("rdwr_both", 1'b1, 1'b1, 32'h08, 32'h1122_3344, 0, 32'hFFFF_0000, 1'b1);

        check("scoreboard:empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_nano_dbus_bridge
